// File: rtl/l2_egress_arb.sv
// Round-robin egress scheduler: serializes a 14-byte header then streams the body of one
// granted ingress port into the shared TX FIFO. Define ARB_WATCHDOG_EN to build the stall watchdog.
module l2_egress_arb #(
    parameter int N_PORTS = 4,
    parameter int TIMEOUT = 1023,
    localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [N_PORTS*112-1:0] h_fifo_dout,
    input  logic [N_PORTS-1:0]     h_fifo_empty,
    output logic [N_PORTS-1:0]     h_fifo_rden,
    input  logic [N_PORTS*8-1:0]   b_fifo_dout,
    input  logic [N_PORTS-1:0]     b_fifo_del,
    input  logic [N_PORTS-1:0]     b_fifo_empty,
    output logic [N_PORTS-1:0]     b_fifo_rden,
    output logic [7:0]             o_fifo_din,
    output logic                   o_fifo_wren,
    output logic                   o_fifo_del,
    input  logic                   o_fifo_afull,
    output logic [GW-1:0]          grant,
    output logic                   busy,
    output logic                   abort
);

    generate
        if (N_PORTS < 2 || N_PORTS > 8 || TIMEOUT < 1) begin : g_param_check
            $error("l2_egress_arb: N_PORTS must be 2..8 and TIMEOUT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_END} state_t;

    state_t        r_state, w_state_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic [GW-1:0] r_grant, w_grant_next;
    logic [7:0]    r_din, w_din_next;
    logic          r_wren, w_wren_next;
    logic          r_del, w_del_next;

    // Per-port views of the flat input buses; header byte 0 lives in w_hdr[p][13].
    logic [13:0][7:0]   w_hdr  [N_PORTS];
    logic [7:0]         w_body [N_PORTS];
    logic [N_PORTS-1:0] w_elig;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign w_hdr[gi]  = h_fifo_dout[gi*112 +: 112];
            assign w_body[gi] = b_fifo_dout[gi*8 +: 8];
            assign w_elig[gi] = ~h_fifo_empty[gi] & ~b_fifo_empty[gi];
        end
    endgenerate

    // Round-robin search from grant+1; iterating farthest-first lets the nearest eligible port win.
    logic          w_found;
    logic [GW-1:0] w_winner;
    always_comb begin
        int v;
        v        = 0;
        w_found  = 1'b0;
        w_winner = r_grant;
        for (int k = N_PORTS; k >= 1; k--) begin
            v = int'(r_grant) + k;
            if (v >= N_PORTS) v = v - N_PORTS;
            if (w_elig[v[GW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = v[GW-1:0];
            end
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] r_stall, w_stall_next;
    logic          r_abort, w_abort_next;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant_next = r_grant;
        w_din_next   = r_din;
        w_wren_next  = 1'b0;
        w_del_next   = 1'b0;
        h_fifo_rden  = '0;
        b_fifo_rden  = '0;
`ifdef ARB_WATCHDOG_EN
        w_stall_next = r_stall;
        w_abort_next = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found && !o_fifo_afull) begin
                    w_grant_next = w_winner;
                    w_cnt_next   = 4'd0;
                    w_state_next = S_HEADER;
                end
            end
            S_HEADER: begin
                if (!o_fifo_afull) begin
                    w_wren_next = 1'b1;
                    w_din_next  = w_hdr[r_grant][4'd13 - r_cnt];
                    w_cnt_next  = r_cnt + 4'd1;
                    // Header is popped only together with its final byte.
                    if (r_cnt == 4'd13) begin
                        h_fifo_rden[r_grant] = 1'b1;
                        w_state_next         = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!b_fifo_empty[r_grant] && !o_fifo_afull) begin
                    w_wren_next          = 1'b1;
                    w_din_next           = w_body[r_grant];
                    b_fifo_rden[r_grant] = 1'b1;
`ifdef ARB_WATCHDOG_EN
                    w_stall_next         = '0;
`endif
                    if (b_fifo_del[r_grant]) begin
                        w_del_next   = 1'b1;
                        w_state_next = S_END;
                    end
                end
`ifdef ARB_WATCHDOG_EN
                else if (r_stall == SW'(TIMEOUT) && !o_fifo_afull) begin
                    // Close the stuck frame with a delimited filler byte.
                    w_wren_next  = 1'b1;
                    w_din_next   = 8'h00;
                    w_del_next   = 1'b1;
                    w_abort_next = 1'b1;
                    w_state_next = S_END;
                end else if (b_fifo_empty[r_grant] && r_stall != SW'(TIMEOUT)) begin
                    w_stall_next = r_stall + 1'b1;
                end
`endif
            end
            S_END: begin
                w_cnt_next   = 4'd0;
`ifdef ARB_WATCHDOG_EN
                w_stall_next = '0;
`endif
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_END;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_grant <= GW'(N_PORTS - 1);
            r_din   <= 8'h00;
            r_wren  <= 1'b0;
            r_del   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_grant <= w_grant_next;
            r_din   <= w_din_next;
            r_wren  <= w_wren_next;
            r_del   <= w_del_next;
        end
    end

`ifdef ARB_WATCHDOG_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_stall <= '0;
            r_abort <= 1'b0;
        end else begin
            r_stall <= w_stall_next;
            r_abort <= w_abort_next;
        end
    end
    assign abort = r_abort;
`else
    assign abort = 1'b0;
`endif

    assign o_fifo_din  = r_din;
    assign o_fifo_wren = r_wren;
    assign o_fifo_del  = r_del;
    assign grant       = r_grant;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_l2_egress_arb.sv
// Bench for l2_egress_arb: queue-backed FWFT ingress FIFOs, a frame-level reference model
// checked every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_l2_egress_arb;
    localparam int N          = 4;
    localparam int GW         = 2;
    localparam int TB_TIMEOUT = 8;
`ifdef ARB_WATCHDOG_EN
    localparam int GAP = 6;
`else
    localparam int GAP = 10;
`endif

    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic [N*112-1:0] h_fifo_dout;
    logic [N-1:0]     h_fifo_empty, h_fifo_rden;
    logic [N*8-1:0]   b_fifo_dout;
    logic [N-1:0]     b_fifo_del, b_fifo_empty, b_fifo_rden;
    logic [7:0]       o_fifo_din;
    logic             o_fifo_wren, o_fifo_del;
    logic             o_fifo_afull = 1'b0;
    logic [GW-1:0]    grant;
    logic             busy, abort;

    l2_egress_arb #(.N_PORTS(N), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .arst(arst),
        .h_fifo_dout(h_fifo_dout), .h_fifo_empty(h_fifo_empty), .h_fifo_rden(h_fifo_rden),
        .b_fifo_dout(b_fifo_dout), .b_fifo_del(b_fifo_del), .b_fifo_empty(b_fifo_empty),
        .b_fifo_rden(b_fifo_rden),
        .o_fifo_din(o_fifo_din), .o_fifo_wren(o_fifo_wren), .o_fifo_del(o_fifo_del),
        .o_fifo_afull(o_fifo_afull), .grant(grant), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    logic [111:0] hq   [N][$];
    logic [8:0]   bq   [N][$];
    logic [8:0]   pend [N][$];
    logic [8:0]   wr_log [$];
    int           hpop_log [$];
    int           abort_cnt = 0;
    int           checks = 0, failures = 0;
    bit           rnd_en = 1'b0;
    logic [N-1:0] cap_h = '0, cap_b = '0;

    int         exp_ord [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_b   [5] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drive();
        logic [8:0] e;
        for (int p = 0; p < N; p++) begin
            h_fifo_empty[p] = (hq[p].size() == 0);
            h_fifo_dout[p*112 +: 112] = (hq[p].size() != 0) ? hq[p][0] : 112'h0;
            e = (bq[p].size() != 0) ? bq[p][0] : 9'h0;
            b_fifo_empty[p] = (bq[p].size() == 0);
            b_fifo_dout[p*8 +: 8] = e[7:0];
            b_fifo_del[p] = e[8];
        end
    endtask

    task automatic push_frame(input int p, input logic [111:0] hdr, input int len,
                              input logic [7:0] b0, input bit trickle);
        logic [8:0] e;
        hq[p].push_back(hdr);
        for (int i = 0; i < len; i++) begin
            e = {(i == len - 1), b0 + 8'(i)};
            if (trickle) pend[p].push_back(e);
            else bq[p].push_back(e);
        end
    endtask

    function automatic logic [111:0] rnd_hdr();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[111:0];
    endfunction

    task automatic step();
        int p;
        @(posedge clk);
        #1;
        for (int q = 0; q < N; q++) begin
            if (cap_h[q] && hq[q].size() != 0) hq[q].delete(0);
            if (cap_b[q] && bq[q].size() != 0) bq[q].delete(0);
            if (pend[q].size() != 0 && ($urandom % 2 == 0)) bq[q].push_back(pend[q].pop_front());
        end
        if (rnd_en) begin
            if ($urandom % 6 == 0) begin
                p = int'($urandom % N);
                if (hq[p].size() < 4) push_frame(p, rnd_hdr(), 1 + int'($urandom % 6), 8'($urandom), 1'b1);
            end
            o_fifo_afull = ($urandom % 5 == 0);
        end
        drive();
    endtask

    function automatic bit idle_now();
        bit r;
        r = !busy;
        for (int q = 0; q < N; q++)
            if (hq[q].size() != 0 || pend[q].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!idle_now()) begin
            if (n >= limit) begin
                checks++;
                failures++;
                $display("FAIL wait_idle: still busy after %0d cycles, required idle", limit);
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic flush();
        for (int q = 0; q < N; q++) begin
            hq[q].delete();
            bq[q].delete();
            pend[q].delete();
        end
        drive();
    endtask

    // Reference model: frame-level view (who holds the port, which byte of the frame is next).
    logic       nx_wren = 1'b0, nx_del = 1'b0, nx_abort = 1'b0;
    logic [7:0] nx_din = 8'h0;
    bit         m_active = 1'b0, m_end = 1'b0;
    int         m_port = 0, m_pos = 0, m_stall = 0, m_grant = N - 1;

    always @(negedge clk) begin
        logic [N-1:0] e_h, e_b;
        logic         w, d, a;
        logic [7:0]   b;
        int           win, q;
        cap_h = h_fifo_rden;
        cap_b = b_fifo_rden;
        if (arst) begin
            m_active = 1'b0; m_end = 1'b0; m_pos = 0; m_stall = 0; m_grant = N - 1;
            nx_wren = 1'b0; nx_del = 1'b0; nx_abort = 1'b0;
        end else begin
            chk("o_fifo_wren", o_fifo_wren, nx_wren);
            if (nx_wren) begin
                chk("o_fifo_din", o_fifo_din, nx_din);
                chk("o_fifo_del", o_fifo_del, nx_del);
            end
            chk("abort", abort, nx_abort);
            if (o_fifo_wren) wr_log.push_back({o_fifo_del, o_fifo_din});
            if (abort) abort_cnt++;
            chk("busy", busy, m_active);
            chk("grant", grant, m_grant);
            e_h = '0; e_b = '0; w = 1'b0; d = 1'b0; a = 1'b0; b = 8'h0;
            if (!m_active) begin
                win = -1;
                for (int k = 1; k <= N; k++) begin
                    q = (m_grant + k) % N;
                    if (win < 0 && !h_fifo_empty[q] && !b_fifo_empty[q]) win = q;
                end
                if (win >= 0 && !o_fifo_afull) begin
                    m_active = 1'b1; m_port = win; m_grant = win; m_pos = 0; m_stall = 0;
                end
            end else if (m_end) begin
                m_active = 1'b0;
                m_end = 1'b0;
            end else if (m_pos < 14) begin
                if (!o_fifo_afull) begin
                    w = 1'b1;
                    b = h_fifo_dout[m_port*112 + (13 - m_pos)*8 +: 8];
                    if (m_pos == 13) e_h[m_port] = 1'b1;
                    m_pos++;
                end
            end else begin
                if (!b_fifo_empty[m_port] && !o_fifo_afull) begin
                    w = 1'b1;
                    b = b_fifo_dout[m_port*8 +: 8];
                    e_b[m_port] = 1'b1;
                    m_stall = 0;
                    if (b_fifo_del[m_port]) begin
                        d = 1'b1;
                        m_end = 1'b1;
                    end
                end
`ifdef ARB_WATCHDOG_EN
                else if (m_stall >= TB_TIMEOUT && !o_fifo_afull) begin
                    w = 1'b1; b = 8'h00; d = 1'b1; a = 1'b1; m_end = 1'b1;
                end else if (b_fifo_empty[m_port] && m_stall < TB_TIMEOUT) begin
                    m_stall++;
                end
`endif
            end
            chk("h_fifo_rden", h_fifo_rden, e_h);
            chk("b_fifo_rden", b_fifo_rden, e_b);
            for (int p = 0; p < N; p++)
                if (h_fifo_rden[p]) hpop_log.push_back(p);
            nx_wren = w; nx_din = b; nx_del = d; nx_abort = a;
        end
    end

    task automatic do_reset();
        arst = 1'b1;
        flush();
        repeat (2) step();
        arst = 1'b0;
        step();
    endtask

    initial begin
        int base, hbase, abase;
        drive();
        #1;
        do_reset();
        chk("reset_grant", grant, N - 1);
        chk("reset_busy", busy, 0);
        chk("reset_wren", o_fifo_wren, 0);
        chk("reset_din", o_fifo_din, 0);

        // Single frame on port 0 with a known header.
        base = wr_log.size(); hbase = hpop_log.size();
        push_frame(0, 112'h0102030405060708090A0B0C0D0E, 3, 8'hAA, 1'b0);
        drive();
        repeat (30) step();
        chk("t1_len", wr_log.size() - base, 17);
        for (int i = 0; i < 17; i++) begin
            if (wr_log.size() > base + i) begin
                chk("t1_byte", wr_log[base+i][7:0], (i < 14) ? i + 1 : 8'hAA + i - 14);
                chk("t1_del", wr_log[base+i][8], (i == 16));
            end
        end
        chk("t1_hpops", hpop_log.size() - hbase, 1);
        chk("t1_grant", grant, 0);

        // Four ports eligible, port 0 twice: strict rotation and contiguous frames.
        do_reset();
        base = wr_log.size(); hbase = hpop_log.size();
        push_frame(0, rnd_hdr(), 1, 8'h00, 1'b0);
        push_frame(0, rnd_hdr(), 1, 8'h01, 1'b0);
        for (int p = 1; p < N; p++) push_frame(p, rnd_hdr(), 1, 8'(p * 16), 1'b0);
        drive();
        repeat (100) step();
        chk("t2_hpops", hpop_log.size() - hbase, 5);
        chk("t2_len", wr_log.size() - base, 75);
        for (int f = 0; f < 5; f++) begin
            if (hpop_log.size() > hbase + f) chk("t2_order", hpop_log[hbase+f], exp_ord[f]);
            if (wr_log.size() > base + 15*f + 14) chk("t2_last", wr_log[base+15*f+14], {1'b1, exp_b[f]});
        end

        // afull held for 5 cycles when header byte 6 is due.
        wait_idle(200);
        base = wr_log.size();
        push_frame(1, 112'hA0A1A2A3A4A5A6A7A8A9AAABACAD, 1, 8'h5A, 1'b0);
        drive();
        repeat (7) step();
        o_fifo_afull = 1'b1;
        repeat (5) step();
        o_fifo_afull = 1'b0;
        repeat (9) step();
        chk("t3_len_c21", wr_log.size() - base, 14);
        step();
        chk("t3_len_c22", wr_log.size() - base, 15);
        for (int i = 0; i < 14; i++)
            if (wr_log.size() > base + i) chk("t3_byte", wr_log[base+i], {1'b0, 8'hA0 + 8'(i)});

        // Body FIFO runs dry mid-payload.
        wait_idle(200);
        base = wr_log.size();
        hq[2].push_back(rnd_hdr());
        bq[2].push_back({1'b0, 8'h61});
        bq[2].push_back({1'b0, 8'h62});
        drive();
        repeat (17 + GAP) step();
        chk("t4_len_stall", wr_log.size() - base, 16);
        bq[2].push_back({1'b0, 8'h63});
        bq[2].push_back({1'b1, 8'h64});
        drive();
        repeat (10) step();
        chk("t4_len", wr_log.size() - base, 18);
        if (wr_log.size() != 0) chk("t4_last", wr_log[$], 9'h164);

`ifdef ARB_WATCHDOG_EN
        // Watchdog: body stops after 2 bytes, frame is closed with a delimited 0x00.
        wait_idle(200);
        base = wr_log.size(); abase = abort_cnt; hbase = hpop_log.size();
        hq[3].push_back(rnd_hdr());
        bq[3].push_back({1'b0, 8'h71});
        bq[3].push_back({1'b0, 8'h72});
        drive();
        repeat (40) step();
        chk("t5_aborts", abort_cnt - abase, 1);
        chk("t5_len", wr_log.size() - base, 17);
        if (wr_log.size() != 0) chk("t5_last", wr_log[$], 9'h100);
        push_frame(3, rnd_hdr(), 1, 8'h33, 1'b0);
        push_frame(0, rnd_hdr(), 1, 8'h03, 1'b0);
        drive();
        repeat (40) step();
        if (hpop_log.size() > hbase + 1) chk("t5_next", hpop_log[hbase+1], 0);
        else chk("t5_next_cnt", hpop_log.size() - hbase, 3);
`else
        abase = abort_cnt;
`endif

        // Asynchronous reset in the middle of the payload.
        wait_idle(200);
        push_frame(0, rnd_hdr(), 6, 8'h80, 1'b0);
        drive();
        repeat (18) step();
        chk("t6_wren_before", o_fifo_wren, 1);
        arst = 1'b1;
        #1;
        chk("t6_wren", o_fifo_wren, 0);
        chk("t6_din", o_fifo_din, 0);
        chk("t6_del", o_fifo_del, 0);
        chk("t6_busy", busy, 0);
        chk("t6_abort", abort, 0);
        chk("t6_hrden", h_fifo_rden, 0);
        chk("t6_brden", b_fifo_rden, 0);
        chk("t6_grant", grant, N - 1);
        flush();
        repeat (2) step();
        arst = 1'b0;
        hbase = hpop_log.size();
        push_frame(2, rnd_hdr(), 2, 8'h22, 1'b0);
        push_frame(0, rnd_hdr(), 2, 8'h02, 1'b0);
        drive();
        repeat (45) step();
        chk("t6_pops", hpop_log.size() - hbase, 2);
        if (hpop_log.size() > hbase) chk("t6_first", hpop_log[hbase], 0);

        // Randomized traffic with trickling bodies and random backpressure.
        wait_idle(200);
        rnd_en = 1'b1;
        repeat (4000) step();
        rnd_en = 1'b0;
        o_fifo_afull = 1'b0;
        drive();
        wait_idle(3000);
        flush();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/l2_egress_arb.md
# l2_egress_arb

Round-robin egress scheduler for the L2 switch. Shares one egress byte path (TX FIFO) among N_PORTS ingress header/body FIFO pairs filled by the MAC decoders. Per granted frame it:
- serializes the 112-bit header (14 bytes, MSB byte first);
- streams the body FIFO until the end-of-frame delimiter;
- marks the last byte with a delimiter and rotates the grant.

## Interface
- N_PORTS, 4, number of ingress FIFO pairs (2..8)
- TIMEOUT, 1023, stall cycles before a frame is aborted (only with ARB_WATCHDOG_EN)
- clk  in  1  clock, all logic on rising edge
- arst  in  1  asynchronous, active-high reset
- h_fifo_dout  in  N_PORTS*112  header words; port i at [i*112 +: 112], FWFT (valid while not empty)
- h_fifo_empty  in  N_PORTS  header FIFO empty, per port
- h_fifo_rden  out  N_PORTS  header pop, per port
- b_fifo_dout  in  N_PORTS*8  body bytes; port i at [i*8 +: 8], FWFT
- b_fifo_del  in  N_PORTS  head byte is the last byte of its frame
- b_fifo_empty  in  N_PORTS  body FIFO empty
- b_fifo_rden  out  N_PORTS  body pop
- o_fifo_din  out  8  egress byte
- o_fifo_wren  out  1  egress write strobe
- o_fifo_del  out  1  qualifies o_fifo_din as last byte of frame
- o_fifo_afull  in  1  egress almost full; must assert with ≥2 free entries
- grant  out  clog2(N_PORTS)  currently/last granted port
- busy  out  1  frame in progress (state != S_IDLE)
- abort  out  1  one-cycle pulse on watchdog abort (tied 0 without ARB_WATCHDOG_EN)

## Operation
- States:
  - S_IDLE: eligible port exists (h_fifo_empty[i]=0 and b_fifo_empty[i]=0) and o_fifo_afull=0 → latch winner into grant, cnt=0, go S_HEADER.
  - S_HEADER: on each cycle with o_fifo_afull=0, write header byte cnt (byte 0 = h_fifo_dout[111:104]) and increment cnt. At cnt=13, pulse h_fifo_rden[grant] for that cycle, then go S_PAYLOAD.
  - S_PAYLOAD: on each cycle with b_fifo_empty[grant]=0 and o_fifo_afull=0, write b_fifo_dout[grant] and pulse b_fifo_rden[grant]. If b_fifo_del[grant]=1 on that byte, set o_fifo_del with it and go S_END.
  - S_END: one cycle, clears cnt and the watchdog, then S_IDLE.
  - Undefined state → S_END.
- Arbitration is round-robin. Search starts at grant+1 mod N_PORTS; the first eligible port wins. grant updates only on leaving S_IDLE.
- Only the granted port sees rden. All other rden bits are 0.
- rden outputs are combinational from state and inputs. o_fifo_din, o_fifo_wren and o_fifo_del are registered.
- Reset values:
  - state S_IDLE, cnt 0
  - all rden outputs 0
  - o_fifo_din 0, o_fifo_wren 0, o_fifo_del 0
  - busy 0, abort 0
  - grant N_PORTS-1, so port 0 wins first
- arst mid-frame: immediate return to S_IDLE with no delimiter emitted. The partial frame in the egress FIFO is the downstream's problem.
- Header pop happens only after all 14 bytes are written. The header is never popped early.

## Timing
- Write latency: o_fifo_wren/o_fifo_din appear 1 cycle after the cycle the byte was selected (and popped, in S_PAYLOAD).
- o_fifo_afull is sampled in the selecting cycle. Because of the 1-cycle write latency, the egress FIFO must keep ≥2 free entries when it asserts afull.
- Minimum frame overhead: 1 cycle (S_IDLE grant) + 14 header cycles + payload bytes + 1 cycle (S_END).
- Back-to-back frames: the next grant occurs in the S_IDLE cycle that follows S_END.
- Simultaneous body-empty and afull: no write, no pop, cnt holds.
- A byte is written only when both conditions allow it, in the same cycle as its pop.

## Configuration
- ARB_WATCHDOG_EN defined:
  - A stall counter increments in S_PAYLOAD on each cycle where b_fifo_empty[grant]=1. Any write clears it.
  - When the counter reaches TIMEOUT, the block writes one byte 0x00 with o_fifo_del=1, pulses abort, and goes to S_END.
  - Stalls caused by o_fifo_afull never count.
- ARB_WATCHDOG_EN undefined:
  - No counter is built and abort is tied to 0.
  - S_PAYLOAD waits indefinitely for body data.

## Test plan
- Reset, then port 0 only, 14-byte header 0x0102..0E, 3-byte body ending with del → o_fifo_din sequence 01..0E then the 3 body bytes; o_fifo_del=1 on the 17th write only; h_fifo_rden[0] pulses once; grant=0.
- All 4 ports eligible, 1-byte bodies → grant order 0,1,2,3,0; no interleaving of bytes between frames.
- o_fifo_afull held high for 5 cycles at header byte 6 → writes pause exactly 5 cycles; no duplicated or dropped byte; cnt resumes at 6.
- Body FIFO empties mid-payload for 10 cycles (watchdog off) → no writes and no rden in that window; stream resumes intact.
- ARB_WATCHDOG_EN with TIMEOUT=8, body empty after 2 bytes → after 8 stall cycles a 0x00 byte is written with del=1, abort pulses 1 cycle, and the next port is granted.
- arst asserted at payload byte 3 → all outputs return to 0 asynchronously; after release the first grant goes to port 0.
